// File: rtl/bsg_cgol_pkg.sv
// Shared types and defaults for the Game of Life controller.
// Holds the controller state encoding and default board/game sizes.
package bsg_cgol_pkg;

  localparam int unsigned board_width_default_lp     = 8;
  localparam int unsigned max_game_length_default_lp = 1024;

  typedef enum logic [1:0] {
    eWAIT,
    eBUSY,
    eDONE
  } bsg_cgol_state_e;

endpackage

// File: rtl/bsg_cgol_gen_counter.sv
// Generation counter: clear_i zeroes, incr_i steps, last_o flags count==target-1.
// Ports: clk_i, reset_n_i (async low), clear_i, incr_i, target_i, count_o, last_o.
module bsg_cgol_gen_counter
  import bsg_cgol_pkg::*;
#(
  parameter int width_p = 11
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               clear_i,
  input  logic               incr_i,
  input  logic [width_p-1:0] target_i,
  output logic [width_p-1:0] count_o,
  output logic               last_o
);

  logic [width_p-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (incr_i) begin
      count_d = count_q + width_p'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  // Only consulted while running, where target is never 0.
  assign last_o  = (count_q == target_i - width_p'(1));

endmodule

// File: rtl/bsg_cgol_ctrl.sv
// Game controller: loads a board into the cell array, runs N generations,
// and returns the result. Ports: game in (data_i/frames_i/v_i/ready_o),
// cell array (en_o/update_o/update_val_o/cells_data_i), result out
// (data_o/v_o/yumi_i) and gen_count_o.
module bsg_cgol_ctrl
  import bsg_cgol_pkg::*;
#(
  parameter  int board_width_p     = board_width_default_lp,
  parameter  int max_game_length_p = max_game_length_default_lp,
  localparam int cells_lp          = board_width_p * board_width_p,
  localparam int len_width_lp      = $clog2(max_game_length_p + 1)
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic [cells_lp-1:0]     data_i,
  input  logic [len_width_lp-1:0] frames_i,
  input  logic                    v_i,
  output logic                    ready_o,
  output logic                    en_o,
  output logic                    update_o,
  output logic [cells_lp-1:0]     update_val_o,
  input  logic [cells_lp-1:0]     cells_data_i,
  output logic [cells_lp-1:0]     data_o,
  output logic                    v_o,
  input  logic                    yumi_i,
  output logic [len_width_lp-1:0] gen_count_o
);

  localparam logic [len_width_lp-1:0] max_len_lp =
    len_width_lp'(max_game_length_p);

  bsg_cgol_state_e         state_q, state_d;
  logic [len_width_lp-1:0] target_q, target_d;
  logic [len_width_lp-1:0] frames_clamped;
  logic                    cnt_clear, cnt_incr, cnt_last;

  assign frames_clamped = (frames_i > max_len_lp) ? max_len_lp : frames_i;

  bsg_cgol_gen_counter #(
    .width_p (len_width_lp)
  ) u_gen_counter (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .clear_i   (cnt_clear),
    .incr_i    (cnt_incr),
    .target_i  (target_q),
    .count_o   (gen_count_o),
    .last_o    (cnt_last)
  );

  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    ready_o   = 1'b0;
    en_o      = 1'b0;
    update_o  = 1'b0;
    v_o       = 1'b0;
    cnt_clear = 1'b0;
    cnt_incr  = 1'b0;
    unique case (state_q)
      eWAIT: begin
        ready_o  = 1'b1;
        // Cells load on the same edge that accepts the game.
        update_o = v_i;
        if (v_i) begin
          target_d  = frames_clamped;
          cnt_clear = 1'b1;
          state_d   = (frames_clamped == '0) ? eDONE : eBUSY;
        end
      end
      eBUSY: begin
        en_o     = 1'b1;
        cnt_incr = 1'b1;
        if (cnt_last) begin
          state_d = eDONE;
        end
      end
      eDONE: begin
        v_o = 1'b1;
        if (yumi_i) begin
          state_d = eWAIT;
        end
      end
      default: begin
        state_d = eWAIT;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= eWAIT;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
    end
  end

  assign update_val_o = update_o ? data_i : '0;
  assign data_o       = v_o ? cells_data_i : '0;

endmodule

// File: tb/tb_bsg_cgol_ctrl.sv
// Bench for bsg_cgol_ctrl: stand-in cell array plus scoreboard of
// reference Game of Life results.
module tb_bsg_cgol_ctrl;

  localparam int W     = 8;
  localparam int MAXL  = 1000;
  localparam int CELLS = W * W;
  localparam int LW    = $clog2(MAXL + 1);

  logic             clk = 1'b0;
  logic             reset_n;
  logic [CELLS-1:0] data_i;
  logic [LW-1:0]    frames_i;
  logic             v_i;
  logic             ready_o;
  logic             en_o;
  logic             update_o;
  logic [CELLS-1:0] update_val_o;
  logic [CELLS-1:0] cells;
  logic [CELLS-1:0] data_o;
  logic             v_o;
  logic             yumi_i;
  logic [LW-1:0]    gen_count_o;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [CELLS-1:0] board;
    int               tgt;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  bsg_cgol_ctrl #(
    .board_width_p     (W),
    .max_game_length_p (MAXL)
  ) dut (
    .clk_i        (clk),
    .reset_n_i    (reset_n),
    .data_i       (data_i),
    .frames_i     (frames_i),
    .v_i          (v_i),
    .ready_o      (ready_o),
    .en_o         (en_o),
    .update_o     (update_o),
    .update_val_o (update_val_o),
    .cells_data_i (cells),
    .data_o       (data_o),
    .v_o          (v_o),
    .yumi_i       (yumi_i),
    .gen_count_o  (gen_count_o)
  );

  // Reference Life step on a dead-bordered W x W board.
  function automatic logic [CELLS-1:0] life(input logic [CELLS-1:0] b);
    logic [CELLS-1:0] n;
    int cnt, rr, cc;
    n = '0;
    for (int r = 0; r < W; r++) begin
      for (int c = 0; c < W; c++) begin
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            rr = r + dr;
            cc = c + dc;
            if ((dr != 0 || dc != 0) && rr >= 0 && rr < W &&
                cc >= 0 && cc < W && b[rr*W+cc])
              cnt++;
          end
        end
        n[r*W+c] = (cnt == 3) || (b[r*W+c] && cnt == 2);
      end
    end
    return n;
  endfunction

  // Stand-in for the cell array driven by the controller.
  initial cells = '0;
  always @(posedge clk) begin
    if (update_o) cells <= update_val_o;
    else if (en_o) cells <= life(cells);
  end

  task automatic check(input string nm, input logic [CELLS-1:0] act,
                       input logic [CELLS-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    tests++;
    fails++;
    $display("FAIL %s: timed out", nm);
  endtask

  // Monitor: per-cycle invariants and scoreboard comparison on v_o rise.
  int cyc = 0;
  int hs_cyc = 0;
  int en_cnt = 0;
  logic v_prev = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    check("en_update_excl", CELLS'(en_o & update_o), '0);
    if (!update_o) check("update_val_idle", update_val_o, '0);
    tests++;
    assert (!(yumi_i && !v_o)) else begin
      fails++;
      $display("FAIL yumi_outside_done: yumi=%b v_o=%b", yumi_i, v_o);
    end
    if (!reset_n) begin
      en_cnt = 0;
      v_prev = 1'b0;
    end else begin
      if (v_i && ready_o) begin
        hs_cyc = cyc;
        en_cnt = 0;
      end
      if (en_o) en_cnt++;
      if (v_o && !v_prev) begin
        if (sb.size() == 0) begin
          timeout("sb_empty_on_v_o");
        end else begin
          e = sb.pop_front();
          check("board", data_o, e.board);
          check("gen_count", CELLS'(gen_count_o), CELLS'(e.tgt));
          check("en_cycles", CELLS'(en_cnt), CELLS'(e.tgt));
          check("latency", CELLS'(cyc - hs_cyc), CELLS'(e.tgt + 1));
        end
      end
      v_prev = v_o;
    end
  end

  task automatic play(input logic [CELLS-1:0] board, input int frames,
                      input int hold, input bit chk_c,
                      input logic [CELLS-1:0] cval);
    int n, tgt;
    logic [CELLS-1:0] e, snap;
    n = 0;
    @(posedge clk); #1;
    while (!ready_o && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!ready_o) begin
      timeout("wait_ready");
      return;
    end
    tgt = (frames > MAXL) ? MAXL : frames;
    e = board;
    for (int i = 0; i < tgt; i++) e = life(e);
    sb.push_back('{e, tgt});
    v_i = 1'b1;
    data_i = board;
    frames_i = LW'(frames);
    @(negedge clk);
    check("update_on_accept", CELLS'(update_o), CELLS'(1));
    check("update_val", update_val_o, board);
    @(posedge clk); #1;
    v_i = 1'b0;
    data_i = {$urandom, $urandom};
    frames_i = LW'($urandom);
    n = 0;
    @(negedge clk);
    while (!v_o && n < tgt + 20) begin
      @(negedge clk);
      n++;
    end
    if (!v_o) begin
      timeout("wait_v_o");
      return;
    end
    if (chk_c) check("board_const", data_o, cval);
    snap = data_o;
    repeat (hold) begin
      @(negedge clk);
      check("hold_v_o", CELLS'(v_o), CELLS'(1));
      check("hold_data", data_o, snap);
      check("hold_ready", CELLS'(ready_o), '0);
    end
    @(posedge clk); #1;
    yumi_i = 1'b1;
    @(posedge clk); #1;
    yumi_i = 1'b0;
    @(negedge clk);
    check("ready_after_yumi", CELLS'(ready_o), CELLS'(1));
    check("v_o_after_yumi", CELLS'(v_o), '0);
  endtask

  logic [CELLS-1:0] blinker_h, blinker_v, block;

  initial begin
    int n;
    blinker_h = '0;
    blinker_h[26] = 1'b1; blinker_h[27] = 1'b1; blinker_h[28] = 1'b1;
    blinker_v = '0;
    blinker_v[19] = 1'b1; blinker_v[27] = 1'b1; blinker_v[35] = 1'b1;
    block = '0;
    block[0] = 1'b1; block[1] = 1'b1; block[8] = 1'b1; block[9] = 1'b1;

    reset_n = 1'b0;
    v_i = 1'b0;
    yumi_i = 1'b0;
    data_i = '0;
    frames_i = '0;
    #12;
    check("rst_ready", CELLS'(ready_o), CELLS'(1));
    check("rst_en", CELLS'(en_o), '0);
    check("rst_update", CELLS'(update_o), '0);
    check("rst_v_o", CELLS'(v_o), '0);
    check("rst_update_val", update_val_o, '0);
    check("rst_data_o", data_o, '0);
    check("rst_gen_count", CELLS'(gen_count_o), '0);
    #8;
    reset_n = 1'b1;

    play(blinker_h, 1, 0, 1'b1, blinker_v);
    play(blinker_h, 2, 0, 1'b1, blinker_h);
    play(block, 0, 0, 1'b1, block);
    play(blinker_h, 3, 5, 1'b1, blinker_v);

    // Reset in the middle of a 10-generation game.
    @(posedge clk); #1;
    v_i = 1'b1;
    data_i = blinker_h;
    frames_i = LW'(10);
    @(posedge clk); #1;
    v_i = 1'b0;
    n = 0;
    while (n < 4) begin
      @(negedge clk);
      if (en_o) n++;
    end
    @(posedge clk); #1;
    check("mid_gen_count", CELLS'(gen_count_o), CELLS'(4));
    reset_n = 1'b0;
    #1;
    check("midrst_en", CELLS'(en_o), '0);
    check("midrst_ready", CELLS'(ready_o), CELLS'(1));
    check("midrst_gen_count", CELLS'(gen_count_o), '0);
    @(negedge clk);
    reset_n = 1'b1;
    play(blinker_h, 1, 1, 1'b1, blinker_v);

    // Over-range request is clamped to the maximum game length.
    play({$urandom, $urandom}, (1 << LW) - 1, 2, 1'b0, '0);

    for (int g = 0; g < 16; g++) begin
      play({$urandom, $urandom}, int'($urandom_range(0, 12)),
           int'($urandom_range(0, 3)), 1'b0, '0);
    end

    repeat (3) @(negedge clk);
    check("sb_drained", CELLS'(sb.size()), '0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
